// File: rtl/eth_decap_if.sv
// MAC RX AXI-Stream beat bus into eth_decap; the MAC has no tready, so there is no backpressure.
interface eth_decap_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser);
  modport slave  (input  tvalid, tdata, tkeep, tlast, tuser);
endinterface

// File: rtl/eth_decap.sv
// Tap-link RX decapsulator: checks and strips the 16-byte header, writes payload beats as 74-bit FIFO entries.
// Optional destination MAC filter enabled by defining DECAP_DSTMAC_FILTER_EN.
module eth_decap #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5
`ifdef DECAP_DSTMAC_FILTER_EN
  , parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
`endif
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  eth_decap_if.slave  rx,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        afull,
  output logic [31:0] frames_ok,
  output logic [31:0] frames_drop,
  output logic [15:0] last_seq
);

  typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, DROP, TERM} state_t;

  state_t      state, state_nxt;
  logic        term_pend, term_pend_nxt;
  logic        skip, skip_nxt;
  logic        wr_nxt;
  logic [73:0] din_nxt;
  logic        ok_inc, drop_inc, seq_ld;
  logic [15:0] etype, seq;
  logic        dst_ok;

  // Header fields are big-endian on the wire; byte n sits at tdata[8n+7:8n].
  assign etype = {rx.tdata[39:32], rx.tdata[47:40]};
  assign seq   = {rx.tdata[55:48], rx.tdata[63:56]};

`ifdef DECAP_DSTMAC_FILTER_EN
  logic [47:0] dst;
  assign dst    = {rx.tdata[7:0], rx.tdata[15:8], rx.tdata[23:16],
                   rx.tdata[31:24], rx.tdata[39:32], rx.tdata[47:40]};
  assign dst_ok = (dst == LOCAL_MAC) || (dst == '1);
`else
  assign dst_ok = 1'b1;
`endif

  always_comb begin
    state_nxt     = state;
    term_pend_nxt = term_pend;
    skip_nxt      = skip;
    wr_nxt        = 1'b0;
    din_nxt       = din;
    ok_inc        = 1'b0;
    drop_inc      = 1'b0;
    seq_ld        = 1'b0;

    case (state)
      IDLE: begin
        if (rx.tvalid) begin
          if (rx.tlast) begin
            drop_inc = 1'b1;
          end else if (!dst_ok) begin
            drop_inc  = 1'b1;
            state_nxt = DROP;
          end else begin
            state_nxt = HDR1;
          end
        end
      end

      HDR1: begin
        if (rx.tvalid) begin
          if (rx.tlast || (etype != ETHERTYPE)) begin
            drop_inc  = 1'b1;
            state_nxt = rx.tlast ? IDLE : DROP;
          end else begin
            seq_ld    = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (rx.tvalid) begin
          if (!afull) begin
            wr_nxt  = 1'b1;
            din_nxt = {rx.tlast & ~rx.tuser, rx.tlast, rx.tkeep, rx.tdata};
            if (rx.tlast) begin
              ok_inc    = rx.tuser;
              drop_inc  = ~rx.tuser;
              state_nxt = IDLE;
            end
          end else begin
            drop_inc      = 1'b1;
            term_pend_nxt = 1'b1;
            state_nxt     = rx.tlast ? TERM : DROP;
          end
        end
      end

      DROP: begin
        if (rx.tvalid && rx.tlast)
          state_nxt = term_pend ? TERM : IDLE;
      end

      TERM: begin
        // A frame that starts while the terminator waits is discarded whole and counted once;
        // skip remembers it is still open so it can be finished off in DROP.
        if (rx.tvalid) begin
          if (!skip)
            drop_inc = 1'b1;
          skip_nxt = ~rx.tlast;
        end
        if (!afull) begin
          wr_nxt        = 1'b1;
          din_nxt       = {2'b11, 8'h00, 64'h0};
          term_pend_nxt = 1'b0;
          state_nxt     = skip_nxt ? DROP : IDLE;
          skip_nxt      = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      term_pend   <= 1'b0;
      skip        <= 1'b0;
      wr_en       <= 1'b0;
      din         <= '0;
      frames_ok   <= '0;
      frames_drop <= '0;
      last_seq    <= '0;
    end else begin
      state     <= state_nxt;
      term_pend <= term_pend_nxt;
      skip      <= skip_nxt;
      wr_en     <= wr_nxt;
      din       <= din_nxt;
      if (ok_inc)
        frames_ok <= frames_ok + 32'd1;
      if (drop_inc)
        frames_drop <= frames_drop + 32'd1;
      if (seq_ld)
        last_seq <= seq;
    end
  end

endmodule

// File: tb/tb_eth_decap.sv
// Self-checking bench for eth_decap: directed scenarios plus randomized frames against a frame-level model.
module tb_eth_decap;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;
  localparam logic [15:0] ET        = 16'h88B5;

  logic        clk156    = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        afull     = 1'b0;
  logic        wr_en;
  logic [73:0] din;
  logic [31:0] frames_ok, frames_drop;
  logic [15:0] last_seq;

  eth_decap_if rx ();

  eth_decap dut (
    .clk156      (clk156),
    .sys_rst_n   (sys_rst_n),
    .rx          (rx),
    .wr_en       (wr_en),
    .din         (din),
    .afull       (afull),
    .frames_ok   (frames_ok),
    .frames_drop (frames_drop),
    .last_seq    (last_seq)
  );

  always #5 clk156 = ~clk156;

  int errors = 0;
  int checks = 0;

  logic [73:0] act_q[$];
  logic [73:0] exp_q[$];
  logic [31:0] exp_ok   = '0;
  logic [31:0] exp_drop = '0;
  logic [15:0] exp_seq  = '0;

  // Current frame description
  int          f_len;
  logic [47:0] f_dst;
  logic [15:0] f_et, f_seq;
  logic [63:0] f_data[16];
  logic [7:0]  f_keep[16];
  bit          f_af[16];
  bit          f_user;

  always @(negedge clk156)
    if (sys_rst_n && wr_en)
      act_q.push_back(din);

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] sq,
                             input int len, input bit user, input logic [7:0] last_keep);
    f_len = len; f_dst = dst; f_et = et; f_seq = sq; f_user = user;
    for (int i = 0; i < 16; i++) begin
      f_data[i] = {$urandom, $urandom};
      f_keep[i] = 8'hFF;
      f_af[i]   = 1'b0;
    end
    for (int b = 0; b < 6; b++)
      f_data[0][8*b +: 8] = dst[8*(5-b) +: 8];
    f_data[1][39:32] = et[15:8];
    f_data[1][47:40] = et[7:0];
    f_data[1][55:48] = sq[15:8];
    f_data[1][63:56] = sq[7:0];
    f_keep[len-1] = last_keep;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < f_len; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        @(negedge clk156);
        rx.tvalid = 1'b0; afull = 1'b0;
      end
      @(negedge clk156);
      rx.tvalid = 1'b1;
      rx.tdata  = f_data[i];
      rx.tkeep  = f_keep[i];
      rx.tlast  = (i == f_len - 1);
      rx.tuser  = (i == f_len - 1) ? f_user : 1'b0;
      afull     = f_af[i];
    end
    @(negedge clk156);
    rx.tvalid = 1'b0; rx.tlast = 1'b0; rx.tuser = 1'b0; afull = 1'b0;
  endtask

  // Frame-level expectation: header accepted or one drop; payload passes until afull truncates it.
  task automatic model_frame();
    bit accept;
    bit last;
    accept = (f_len >= 3) && (f_et == ET);
`ifdef DECAP_DSTMAC_FILTER_EN
    if (f_dst != LOCAL_MAC && f_dst != BCAST) accept = 1'b0;
`endif
    if (!accept) begin
      exp_drop++;
      return;
    end
    exp_seq = f_seq;
    for (int i = 2; i < f_len; i++) begin
      last = (i == f_len - 1);
      if (f_af[i]) begin
        exp_drop++;
        exp_q.push_back({2'b11, 72'h0});
        return;
      end
      exp_q.push_back({last & ~f_user, last, f_keep[i], f_data[i]});
      if (last) begin
        if (f_user) exp_ok++;
        else        exp_drop++;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; afull = 1'b0;
    rx.tvalid = 1'b0; rx.tdata = '0; rx.tkeep = '0; rx.tlast = 1'b0; rx.tuser = 1'b0;
    repeat (3) @(negedge clk156);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0h exp=0", wr_en); end
    checks++; if (din !== '0) begin errors++; $display("FAIL reset_din got=%0h exp=0", din); end
    checks++; if (frames_ok !== '0) begin errors++; $display("FAIL reset_frames_ok got=%0h exp=0", frames_ok); end
    checks++; if (frames_drop !== '0) begin errors++; $display("FAIL reset_frames_drop got=%0h exp=0", frames_drop); end
    checks++; if (last_seq !== '0) begin errors++; $display("FAIL reset_last_seq got=%0h exp=0", last_seq); end
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk156);
    checks++; if (wr_en !== 1'b0 || act_q.size() != 0) begin
      errors++; $display("FAIL reset_idle_write got=%0d writes exp=0", act_q.size());
    end
  endtask

  task automatic test_good_frame();
    logic [73:0] lastw;
    build_frame(LOCAL_MAC, ET, 16'h0102, 5, 1'b1, 8'h0F);
    model_frame();
    send_frame(0);
    repeat (3) @(negedge clk156);
    lastw = (act_q.size() > 0) ? act_q[act_q.size()-1] : 'x;
    checks++; if (act_q.size() != 3) begin errors++; $display("FAIL good_nwrites got=%0d exp=3", act_q.size()); end
    checks++; if (lastw[73:72] !== 2'b01 || lastw[71:64] !== 8'h0F) begin
      errors++; $display("FAIL good_last_flags got=%0h/%0h exp=1/0f", lastw[73:72], lastw[71:64]);
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_din[%0d] got=%0h exp=%0h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (frames_ok !== 32'd1) begin errors++; $display("FAIL good_frames_ok got=%0d exp=1", frames_ok); end
    checks++; if (last_seq !== 16'h0102) begin errors++; $display("FAIL good_last_seq got=%0h exp=0102", last_seq); end
    checks++; if (frames_drop !== exp_drop) begin errors++; $display("FAIL good_frames_drop got=%0d exp=%0d", frames_drop, exp_drop); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_ethertype();
    build_frame(LOCAL_MAC, 16'h0800, 16'h7777, 4, 1'b1, 8'hFF);
    model_frame();
    send_frame(0);
    repeat (3) @(negedge clk156);
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL etype_nwrites got=%0d exp=0", act_q.size()); end
    checks++; if (frames_drop !== 32'd1) begin errors++; $display("FAIL etype_frames_drop got=%0d exp=1", frames_drop); end
    checks++; if (last_seq !== 16'h0102) begin errors++; $display("FAIL etype_last_seq got=%0h exp=0102", last_seq); end
    checks++; if (frames_ok !== exp_ok) begin errors++; $display("FAIL etype_frames_ok got=%0d exp=%0d", frames_ok, exp_ok); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_runt();
    logic [31:0] base;
    base = frames_drop;
    build_frame(LOCAL_MAC, ET, 16'h1111, 1, 1'b1, 8'hFF);
    model_frame();
    send_frame(0);
    build_frame(LOCAL_MAC, ET, 16'h2222, 2, 1'b1, 8'hFF);
    model_frame();
    send_frame(0);
    repeat (3) @(negedge clk156);
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL runt_nwrites got=%0d exp=0", act_q.size()); end
    checks++; if (frames_drop !== base + 32'd2) begin errors++; $display("FAIL runt_frames_drop got=%0d exp=%0d", frames_drop, base + 32'd2); end
    checks++; if (frames_drop !== exp_drop) begin errors++; $display("FAIL runt_model_drop got=%0d exp=%0d", frames_drop, exp_drop); end
    checks++; if (last_seq !== 16'h0102) begin errors++; $display("FAIL runt_last_seq got=%0h exp=0102", last_seq); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_fcs();
    logic [73:0] lastw;
    logic [31:0] base;
    base = frames_drop;
    build_frame(LOCAL_MAC, ET, 16'h0304, 4, 1'b0, 8'h3F);
    model_frame();
    send_frame(1);
    repeat (3) @(negedge clk156);
    lastw = (act_q.size() > 0) ? act_q[act_q.size()-1] : 'x;
    checks++; if (act_q.size() != 2) begin errors++; $display("FAIL fcs_nwrites got=%0d exp=2", act_q.size()); end
    checks++; if (lastw[73:72] !== 2'b11) begin errors++; $display("FAIL fcs_err_last got=%0h exp=3", lastw[73:72]); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL fcs_din[%0d] got=%0h exp=%0h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (frames_drop !== base + 32'd1) begin errors++; $display("FAIL fcs_frames_drop got=%0d exp=%0d", frames_drop, base + 32'd1); end
    checks++; if (last_seq !== 16'h0304) begin errors++; $display("FAIL fcs_last_seq got=%0h exp=0304", last_seq); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [31:0] base;
    base = frames_drop;
    build_frame(LOCAL_MAC, ET, 16'h0A0B, 7, 1'b1, 8'hFF);
    for (int i = 3; i < 7; i++) f_af[i] = 1'b1;
    model_frame();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk156);
      rx.tvalid = 1'b1; rx.tdata = f_data[i]; rx.tkeep = f_keep[i];
      rx.tlast = (i == 6); rx.tuser = (i == 6); afull = f_af[i];
    end
    // second frame lands while the terminator is still blocked
    @(negedge clk156);
    rx.tvalid = 1'b1; rx.tdata = {$urandom, $urandom}; rx.tlast = 1'b0; rx.tuser = 1'b0; afull = 1'b1;
    @(negedge clk156);
    rx.tdata = {$urandom, $urandom}; rx.tlast = 1'b1; rx.tuser = 1'b1;
    @(negedge clk156);
    rx.tvalid = 1'b0; rx.tlast = 1'b0; rx.tuser = 1'b0;
    repeat (3) @(negedge clk156);
    checks++; if (act_q.size() != 1) begin errors++; $display("FAIL ovf_writes_while_full got=%0d exp=1", act_q.size()); end
    afull = 1'b0;
    exp_drop++;
    repeat (4) @(negedge clk156);
    checks++; if (act_q.size() != 2) begin errors++; $display("FAIL ovf_nwrites got=%0d exp=2", act_q.size()); end
    checks++; if (act_q.size() < 2 || act_q[1] !== {2'b11, 72'h0}) begin
      errors++; $display("FAIL ovf_terminator got=%0h exp=%0h", (act_q.size() > 1) ? act_q[1] : 'x, {2'b11, 72'h0});
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_din[%0d] got=%0h exp=%0h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (frames_drop !== base + 32'd2) begin errors++; $display("FAIL ovf_frames_drop got=%0d exp=%0d", frames_drop, base + 32'd2); end
    checks++; if (frames_ok !== exp_ok) begin errors++; $display("FAIL ovf_frames_ok got=%0d exp=%0d", frames_ok, exp_ok); end
    checks++; if (last_seq !== 16'h0A0B) begin errors++; $display("FAIL ovf_last_seq got=%0h exp=0a0b", last_seq); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_dst_filter();
    logic [31:0] base;
    logic [31:0] want;
    base = frames_ok;
`ifdef DECAP_DSTMAC_FILTER_EN
    want = base + 32'd2;
`else
    want = base + 32'd3;
`endif
    build_frame(OTHER_MAC, ET, 16'h0011, 3, 1'b1, 8'hFF); model_frame(); send_frame(0);
    build_frame(BCAST,     ET, 16'h0022, 3, 1'b1, 8'hFF); model_frame(); send_frame(0);
    build_frame(LOCAL_MAC, ET, 16'h0033, 3, 1'b1, 8'hFF); model_frame(); send_frame(0);
    repeat (3) @(negedge clk156);
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL dst_nwrites got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL dst_din[%0d] got=%0h exp=%0h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (frames_ok !== want) begin errors++; $display("FAIL dst_frames_ok got=%0d exp=%0d", frames_ok, want); end
    checks++; if (frames_drop !== exp_drop) begin errors++; $display("FAIL dst_frames_drop got=%0d exp=%0d", frames_drop, exp_drop); end
    checks++; if (last_seq !== 16'h0033) begin errors++; $display("FAIL dst_last_seq got=%0h exp=0033", last_seq); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [47:0] dst;
    logic [15:0] et;
    int          len;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3, 0))
        0:       dst = OTHER_MAC;
        1:       dst = BCAST;
        default: dst = LOCAL_MAC;
      endcase
      et  = ($urandom_range(99, 0) < 85) ? ET : 16'($urandom);
      len = int'($urandom_range(8, 1));
      build_frame(dst, et, 16'($urandom), len, ($urandom_range(99, 0) < 85),
                  8'hFF >> $urandom_range(7, 0));
      for (int i = 2; i < len; i++) f_af[i] = ($urandom_range(99, 0) < 8);
      model_frame();
      send_frame((n % 2 == 0) ? 0 : 2);
    end
    repeat (4) @(negedge clk156);
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_nwrites got=%0d exp=%0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_din[%0d] got=%0h exp=%0h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (frames_ok !== exp_ok) begin errors++; $display("FAIL rand_frames_ok got=%0d exp=%0d", frames_ok, exp_ok); end
    checks++; if (frames_drop !== exp_drop) begin errors++; $display("FAIL rand_frames_drop got=%0d exp=%0d", frames_drop, exp_drop); end
    checks++; if (last_seq !== exp_seq) begin errors++; $display("FAIL rand_last_seq got=%0h exp=%0h", last_seq, exp_seq); end
    act_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_ethertype();
    test_runt();
    test_bad_fcs();
    test_overflow();
    test_dst_filter();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
